// File: rtl/matvec_pkg.sv
// Shared types and default sizing for the Minilab1B matrix-vector sequencer.
package matvec_pkg;
  localparam int DEF_NUM_ROWS = 8;
  localparam int DEF_VEC_LEN  = 8;
  localparam int DEF_DATA_W   = 8;
  // The B vector lives in the word right after the last A row.
  localparam int B_ROW_ADDR   = DEF_NUM_ROWS;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_FILL, S_COMPUTE, S_DRAIN, S_DONE
  } sched_state_t;
endpackage

// File: rtl/matvec_sched.sv
// Fetches A rows and B from memory, unpacks them into the row FIFOs, then streams the MAC array.
// Optional SCHED_PERF_EN adds a saturating run-length cycle counter on perf_cycles.
module matvec_sched
  import matvec_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int VEC_LEN  = DEF_VEC_LEN,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = 32,
  parameter int MAC_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_read,
  input  logic [VEC_LEN*DATA_W-1:0] mem_readdata,
  input  logic                      mem_readdatavalid,
  input  logic                      mem_waitrequest,
  output logic                      fifo_clr,
  output logic [NUM_ROWS:0]         fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      fifo_rd_en,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic [31:0]               perf_cycles
);
  localparam int ROW_W   = $clog2(NUM_ROWS + 1);
  localparam int BYTE_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int CYC_MAX = (VEC_LEN > MAC_LAT) ? VEC_LEN : MAC_LAT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int WR_W    = NUM_ROWS + 1;
  localparam int RD_W    = VEC_LEN * DATA_W;

  sched_state_t      state_q, state_n;
  logic [ROW_W-1:0]  row_q, row_n;
  logic [BYTE_W-1:0] byte_q, byte_n;
  logic [CYC_W-1:0]  cyc_q, cyc_n;
  logic [RD_W-1:0]   rowreg_q, rowreg_n;
  logic              accept;

  always_comb begin
    state_n  = state_q;
    row_n    = row_q;
    byte_n   = byte_q;
    cyc_n    = cyc_q;
    rowreg_n = rowreg_q;
    accept   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_n = S_REQ;
        row_n   = '0;
        accept  = 1'b1;
      end
      S_REQ: if (!mem_waitrequest) state_n = S_WAIT;
      S_WAIT: if (mem_readdatavalid) begin
        rowreg_n = mem_readdata;
        byte_n   = '0;
        state_n  = S_FILL;
      end
      S_FILL: begin
        if (byte_q == BYTE_W'(VEC_LEN - 1)) begin
          if (row_q == ROW_W'(NUM_ROWS)) begin
            state_n = S_COMPUTE;
            cyc_n   = '0;
          end else begin
            row_n   = row_q + 1'b1;
            state_n = S_REQ;
          end
        end else begin
          byte_n = byte_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cyc_q == CYC_W'(VEC_LEN - 1)) begin
          state_n = S_DRAIN;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cyc_q == CYC_W'(MAC_LAT - 1)) state_n = S_DONE;
        else                              cyc_n   = cyc_q + 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      byte_q       <= '0;
      cyc_q        <= '0;
      rowreg_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      fifo_clr     <= 1'b0;
      mac_clr      <= 1'b0;
      fifo_wr_en   <= '0;
      fifo_wr_data <= '0;
      fifo_rd_en   <= 1'b0;
      mac_en       <= 1'b0;
    end else begin
      state_q      <= state_n;
      row_q        <= row_n;
      byte_q       <= byte_n;
      cyc_q        <= cyc_n;
      rowreg_q     <= rowreg_n;
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
      mem_read     <= (state_n == S_REQ);
      mem_address  <= (state_n == S_REQ) ? ADDR_W'(row_n) : '0;
      fifo_clr     <= accept;
      mac_clr      <= accept;
      fifo_wr_en   <= (state_n == S_FILL) ? (WR_W'(1) << row_n) : '0;
      fifo_wr_data <= (state_n == S_FILL) ? rowreg_n[byte_n*DATA_W +: DATA_W] : '0;
      fifo_rd_en   <= (state_n == S_COMPUTE);
      mac_en       <= (state_n == S_COMPUTE);
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] perf_q;

  // Counts every non-idle cycle, so the held value equals the run length.
  always_ff @(posedge clk) begin
    if (rst || accept)                         perf_q <= '0;
    else if (state_q != S_IDLE && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
